// File: rtl/dma_xfer_ctrl_if.sv
// Control, arbitration and memory-strobe bundle between the DMA sequencer and its system.
// The shared data bus DB_io stays a plain inout on the sequencer so tristate resolution is simple.
interface dma_xfer_ctrl_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [7:0]    count;
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] Address;
    logic          Enable;
    logic          MemRead;
    logic          DB_tri;
    logic          DB_wrReq;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        input  start, src_addr, dst_addr, count, bus_gnt, DB_wrReq,
        output bus_req, Address, Enable, MemRead, DB_tri, busy, done, error
    );

    modport slave (
        output start, src_addr, dst_addr, count, bus_gnt, DB_wrReq,
        input  bus_req, Address, Enable, MemRead, DB_tri, busy, done, error
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// Single-channel memory-to-memory DMA sequencer on the shared 8-bit memory bus.
// Optional read-wait watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_xfer_ctrl #(
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_xfer_ctrl_if.master bus,
    inout  wire  [DW-1:0]   DB_io
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog (1..256)");
    end

    typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} state_t;

    state_t        state;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [7:0]    cnt;
    logic [DW-1:0] data_q;

`ifdef DMA_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd;
`else
    assign bus.error = 1'b0;
`endif

    // Only the write cycle drives the bus; DB_tri is a registered state decode.
    assign DB_io = bus.DB_tri ? data_q : {DW{1'bz}};

    // NOTE: all state and outputs use non-blocking assignment so every register
    // samples the pre-edge values and the branches below order-independent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
            data_q      <= '0;
            bus.bus_req <= 1'b0;
            bus.Enable  <= 1'b0;
            bus.MemRead <= 1'b0;
            bus.DB_tri  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.Address <= '0;
`ifdef DMA_TIMEOUT_EN
            wd          <= '0;
            bus.error   <= 1'b0;
`endif
        end else begin
            bus.done   <= 1'b0;
            bus.DB_tri <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src <= bus.src_addr;
                        dst <= bus.dst_addr;
                        cnt <= bus.count;
`ifdef DMA_TIMEOUT_EN
                        bus.error <= 1'b0;
`endif
                        if (bus.count != 8'd0) begin
                            state       <= REQ;
                            bus.busy    <= 1'b1;
                            bus.bus_req <= 1'b1;
                        end else begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (bus.bus_gnt) begin
                        state       <= RD;
                        bus.Enable  <= 1'b1;
                        bus.MemRead <= 1'b1;
                        bus.Address <= src;
`ifdef DMA_TIMEOUT_EN
                        wd          <= '0;
`endif
                    end
                end

                RD: begin
                    if (!bus.bus_gnt) begin
                        // Lost the bus mid-wait: back off and re-read the same element.
                        state       <= REQ;
                        bus.Enable  <= 1'b0;
                        bus.MemRead <= 1'b0;
                    end else if (bus.DB_wrReq) begin
                        state       <= WR;
                        data_q      <= DB_io;
                        bus.MemRead <= 1'b0;
                        bus.DB_tri  <= 1'b1;
                        bus.Address <= dst;
`ifdef DMA_TIMEOUT_EN
                    end else if (wd == WD_LAST) begin
                        state       <= FIN;
                        bus.error   <= 1'b1;
                        bus.Enable  <= 1'b0;
                        bus.MemRead <= 1'b0;
                        bus.bus_req <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
`endif
                    end
                end

                WR: begin
                    src        <= src + 1'b1;
                    dst        <= dst + 1'b1;
                    cnt        <= cnt - 8'd1;
                    bus.Enable <= 1'b0;
                    if (cnt == 8'd1) begin
                        state       <= FIN;
                        bus.bus_req <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                    end else begin
                        state <= REQ;
                    end
                end

                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: memory responder, per-cycle block model and
// directed block scenarios (define DMA_TIMEOUT_EN to also exercise the watchdog).
module tb_dma_xfer_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_xfer_ctrl_if #(.AW(AW)) bus ();
    wire [DW-1:0] DB_io;

    dma_xfer_ctrl #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .DB_io (DB_io)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source memory (never written) and a record of what the controller wrote.
    logic [7:0] mem  [256];
    logic [7:0] wmem [256];

    // Memory responder: data valid rd_delay cycles into a read, or never while rd_hold is set.
    int   rd_delay = 0;
    bit   rd_hold  = 1'b0;
    logic rd_ready = 1'b0;
    int   wait_cnt = 0;
    always @(negedge clk) begin
        if (bus.Enable && bus.MemRead) begin
            rd_ready = !rd_hold && (wait_cnt >= rd_delay);
            wait_cnt++;
        end else begin
            rd_ready = 1'b0;
            wait_cnt = 0;
        end
    end
    assign bus.DB_wrReq = rd_ready && bus.Enable && bus.MemRead;
    assign DB_io = (rd_ready && bus.Enable && bus.MemRead) ? mem[bus.Address] : 'z;

    int cyc         = 0;
    bit rst_at_edge = 1'b0;
    bit mon_on      = 1'b0;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst_n;
        if (!rst_n) mon_on <= 1'b1;
    end

    // Block description, written by the stimulus only.
    logic [7:0] m_src, m_dst, m_n;
    int         blk_seq   = 0;
    int         start_cyc = 0;
    bit         expect_to = 1'b0;

    // Model state, written by the monitor only.
    int         seen_seq = 0;
    bit         active   = 1'b0;
    logic [7:0] m_k      = 8'd0;
    int         wr_cnt = 0, rd_cycles = 0, done_cnt = 0, done_lat = 0;
    bit         saw_bus = 1'b0;
    logic [7:0] exp_addr;

    // Element k of a block reads src+k and writes mem[src+k] to dst+k, addresses mod 256.
    always @(negedge clk) begin
        if (mon_on) begin
            if (seen_seq != blk_seq) begin
                seen_seq  = blk_seq;
                active    = 1'b1;
                m_k       = 8'd0;
                wr_cnt    = 0;
                rd_cycles = 0;
                done_cnt  = 0;
                saw_bus   = 1'b0;
            end
            if (rst_at_edge) begin
                check("reset_strobes", {bus.bus_req, bus.Enable, bus.MemRead, bus.DB_tri,
                                        bus.busy, bus.done, bus.error}, 0);
                check("reset_address", bus.Address, 0);
                active = 1'b0;
            end else begin
                check("idle_strobes", !bus.Enable && (bus.MemRead || bus.DB_tri), 0);
                check("tri_only_in_write", bus.DB_tri && !(bus.Enable && !bus.MemRead), 0);
                check("done_busy_exclusive", bus.done && bus.busy, 0);
                check("enable_needs_busy", bus.Enable && !bus.busy, 0);
`ifndef DMA_TIMEOUT_EN
                check("error_tied_low", bus.error, 0);
`endif
                if (bus.bus_req || bus.Enable) saw_bus = 1'b1;
                if (!active) begin
                    check("no_bus_when_inactive", bus.Enable, 0);
                end else begin
                    if (bus.Enable && bus.MemRead) begin
                        rd_cycles++;
                        exp_addr = 8'(m_src + m_k);
                        check("read_address", bus.Address, exp_addr);
                    end
                    if (bus.Enable && !bus.MemRead) begin
                        exp_addr = 8'(m_dst + m_k);
                        check("write_address", bus.Address, exp_addr);
                        exp_addr = 8'(m_src + m_k);
                        check("write_data", DB_io, mem[exp_addr]);
                        wmem[bus.Address] = DB_io;
                        m_k++;
                        wr_cnt++;
                    end
                    if (bus.done) begin
                        done_cnt++;
                        done_lat = cyc - start_cyc;
                        if (!expect_to) check("elements_at_done", m_k, m_n);
                    end
                end
            end
        end
    end

    task automatic run_block(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(negedge clk);
        m_src        = s;
        m_dst        = d;
        m_n          = n;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.count    = n;
        bus.start    = 1'b1;
        start_cyc    = cyc;
        blk_seq++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", done_cnt != 0, 1);
        @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.count    = '0;
        bus.bus_gnt  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h64] = 8'hA5;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_bus_req", bus.bus_req, 0);

        // Single element, ideal bus.
        run_block(8'h64, 8'h80, 8'd1);
        wait_done(20);
        check("t1_data", wmem[8'h80], 8'hA5);
        check("t1_latency", done_lat, 4);
        check("t1_bus_req_released", bus.bus_req, 0);
        check("t1_busy_cleared", bus.busy, 0);

        // Address wrap on the source side.
        run_block(8'hFE, 8'h10, 8'd4);
        wait_done(40);
        check("t2_writes", wr_cnt, 4);
        check("t2_latency", done_lat, 13);
        check("t2_w0", wmem[8'h10], 8'hA4);
        check("t2_w1", wmem[8'h11], 8'hA5);
        check("t2_w2", wmem[8'h12], 8'h5A);
        check("t2_w3", wmem[8'h13], 8'h5B);

        // Empty block.
        run_block(8'h00, 8'h00, 8'd0);
        wait_done(10);
        check("t3_latency", done_lat, 1);
        check("t3_no_bus_activity", saw_bus, 0);
        check("t3_writes", wr_cnt, 0);

        // Grant withdrawn while element 2 of 3 waits for read data.
        rd_delay = 2;
        run_block(8'h20, 8'h40, 8'd3);
        begin
            int n = 0;
            while (!(bus.Enable && bus.MemRead && wr_cnt == 1) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("t4_reached_elem2_read", n < 40, 1);
        end
        bus.bus_gnt = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_enable_dropped", bus.Enable, 0);
            check("t4_still_requesting", bus.bus_req, 1);
        end
        bus.bus_gnt = 1'b1;
        @(negedge clk);
        check("t4_reread_address", bus.Address, 8'h21);
        wait_done(40);
        check("t4_writes", wr_cnt, 3);
        check("t4_w0", wmem[8'h40], 8'h7A);
        check("t4_w1", wmem[8'h41], 8'h7B);
        check("t4_w2", wmem[8'h42], 8'h78);
        rd_delay = 0;

        // Reset in the middle of a write, then a fresh block.
        run_block(8'h30, 8'h50, 8'd5);
        begin
            int n = 0;
            while (!(bus.Enable && !bus.MemRead) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t5_reached_write", n < 20, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_outputs_cleared", {bus.bus_req, bus.Enable, bus.MemRead, bus.DB_tri,
                                     bus.busy, bus.done}, 0);
        check("t5_address_cleared", bus.Address, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_stays_idle", bus.bus_req, 0);
        run_block(8'h70, 8'h90, 8'd2);
        wait_done(30);
        check("t5_latency", done_lat, 7);
        check("t5_w0", wmem[8'h90], 8'h2A);
        check("t5_w1", wmem[8'h91], 8'h2B);

`ifdef DMA_TIMEOUT_EN
        // Read data never arrives: watchdog aborts after 16 read cycles.
        rd_hold   = 1'b1;
        expect_to = 1'b1;
        run_block(8'hA0, 8'hB0, 8'd2);
        wait_done(60);
        check("t6_error_set", bus.error, 1);
        check("t6_no_writes", wr_cnt, 0);
        check("t6_read_cycles", rd_cycles, 16);
        check("t6_latency", done_lat, 18);
        rd_hold   = 1'b0;
        expect_to = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_error_sticky", bus.error, 1);
        run_block(8'hA0, 8'hB0, 8'd1);
        check("t6_error_cleared_on_start", bus.error, 0);
        wait_done(20);
        check("t6_recovery_write", wmem[8'hB0], 8'hFA);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
